// File: rtl/rf_lane_dot_accum.sv
// Pulls packed 5-lane words from the transposition register file, weights each lane,
// and accumulates the lane sums over a programmed word count; result leaves on valid/ready.
module rf_lane_dot_accum #(
    parameter int LANES = 5,
    parameter int BW    = 4,
    parameter int CNT_W = 8,
    parameter int ACC_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_load,
    input  logic [LANES*BW-1:0]   w_data,
    input  logic                  start,
    input  logic [CNT_W-1:0]      n_words,
    input  logic                  rf_empty,
    output logic                  rf_rd_en,
    input  logic [LANES*BW-1:0]   rf_rdata,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      acc_out
);

    localparam int DW    = LANES * BW;
    localparam int SUM_W = 2 * BW + $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [DW-1:0]      weights;
    logic [CNT_W-1:0]   n_reg;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   received;
    logic               pending;
    logic [ACC_W-1:0]   acc;
    logic [SUM_W-1:0]   lane_sum;
    logic               last_word;

    // NOTE: blocking '=' is correct inside always_comb; the running sum is a chain of adders.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'((2*BW)'(rf_rdata[DW-1-BW*i -: BW]) *
                                         (2*BW)'(weights[DW-1-BW*i -: BW]));
        end
    end

    assign last_word = pending && (received == n_reg - CNT_W'(1));

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
        rf_rd_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (n_words == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                rf_rd_en = !rst && !rf_empty && (issued < n_reg);
                if (last_word) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign acc_out = acc;

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            weights  <= '0;
            n_reg    <= '0;
            issued   <= '0;
            received <= '0;
            pending  <= 1'b0;
            acc      <= '0;
        end else begin
            state   <= state_nxt;
            pending <= rf_rd_en;
            if (rf_rd_en) issued <= issued + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    // Weights land on the same edge as start, so a combined load+start uses them.
                    if (w_load) weights <= w_data;
                    if (start) begin
                        n_reg    <= n_words;
                        issued   <= '0;
                        received <= '0;
                        if (n_words == '0) acc <= '0;
                    end
                end
                S_FETCH: begin
                    // The first accumulate replaces the old result, so acc_out holds it until then.
                    if (pending) begin
                        acc      <= ((received == '0) ? '0 : acc) + ACC_W'(lane_sum);
                        received <= received + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_lane_dot_accum.sv
// Bench for rf_lane_dot_accum: a queue-backed register file model feeds the block and a
// lane-by-lane dot-product model supplies every expected result.
module tb_rf_lane_dot_accum;

    localparam int LANES = 5;
    localparam int BW    = 4;
    localparam int CNT_W = 8;
    localparam int ACC_W = 20;
    localparam int DW    = LANES * BW;

    logic             clk = 1'b0;
    logic             rst;
    logic             w_load;
    logic [DW-1:0]    w_data;
    logic             start;
    logic [CNT_W-1:0] n_words;
    logic             rf_empty;
    logic             rf_rd_en;
    logic [DW-1:0]    rf_rdata;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;

    always #5 clk = ~clk;

    rf_lane_dot_accum #(.LANES(LANES), .BW(BW), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data), .start(start),
        .n_words(n_words), .rf_empty(rf_empty), .rf_rd_en(rf_rd_en), .rf_rdata(rf_rdata),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out)
    );

    // Register file stand-in: words pushed by the stimulus, popped by rf_rd_en, registered read data.
    logic [DW-1:0] mem [4096];
    int            wr_cnt = 0;
    int            rd_ptr = 0;
    int            rd_pulses = 0;
    int            underflows = 0;
    logic          force_empty = 1'b0;

    assign rf_empty = force_empty | (rd_ptr == wr_cnt);

    always @(posedge clk) begin
        if (rf_rd_en) begin
            if (rd_ptr == wr_cnt) underflows <= underflows + 1;
            rf_rdata  <= mem[rd_ptr[11:0]];
            rd_ptr    <= rd_ptr + 1;
            rd_pulses <= rd_pulses + 1;
        end
    end

    int vecs   = 0;
    int misses = 0;
    int job_p0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dot(input logic [DW-1:0] w, input logic [DW-1:0] d);
        int s = 0;
        for (int i = 0; i < LANES; i++)
            s += int'(w[DW-1-BW*i -: BW]) * int'(d[DW-1-BW*i -: BW]);
        return s;
    endfunction

    task automatic push(input logic [DW-1:0] d);
        mem[wr_cnt[11:0]] = d;
        wr_cnt++;
    endtask

    task automatic start_job(input logic [DW-1:0] w, input bit do_load, input int n);
        @(negedge clk);
        w_load  = do_load;
        w_data  = w;
        start   = 1'b1;
        n_words = CNT_W'(n);
        job_p0  = rd_pulses;
        @(posedge clk);
        #1;
        w_load = 1'b0;
        start  = 1'b0;
    endtask

    task automatic wait_result(input string nm, input int exp_acc, input int exp_lat,
                               input int ready_dly, input bit rnd_empty, input int exp_pulses);
        int lat = 0;
        bit got = 1'b0;
        while (!got && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (rnd_empty) force_empty = ($urandom_range(0, 2) == 0);
            #1;
            got = out_valid;
        end
        force_empty = 1'b0;
        check({nm, " valid_seen"}, 32'(got), 32'd1);
        if (exp_lat > 0) check({nm, " latency"}, lat, exp_lat);
        check({nm, " acc"}, 32'(acc_out), exp_acc);
        for (int i = 0; i < ready_dly; i++) begin
            @(negedge clk);
            #1;
            check({nm, " hold_valid"}, 32'(out_valid), 32'd1);
            check({nm, " hold_acc"}, 32'(acc_out), exp_acc);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check({nm, " valid_cleared"}, 32'(out_valid), 32'd0);
        check({nm, " idle"}, 32'(busy), 32'd0);
        check({nm, " acc_kept"}, 32'(acc_out), exp_acc);
        check({nm, " rd_pulses"}, rd_pulses - job_p0, exp_pulses);
    endtask

    typedef struct packed {
        logic [DW-1:0]        w;
        logic [7:0]           n;
        logic [3:0][DW-1:0]   d;
        logic [ACC_W-1:0]     exp_acc;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_acc;
        int n;
        logic [DW-1:0] w;
        logic [DW-1:0] d;
        logic [DW-1:0] sw [4];

        tbl[0] = '{w: 20'h12345, n: 8'd3, d: {20'h0, 20'h11111, 20'h00000, 20'hFFFFF}, exp_acc: 20'd240};
        tbl[1] = '{w: 20'hFFFFF, n: 8'd4, d: {20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF}, exp_acc: 20'd4500};
        tbl[2] = '{w: 20'h21000, n: 8'd2, d: {20'h0, 20'h0, 20'h03000, 20'h30000}, exp_acc: 20'd9};
        tbl[3] = '{w: 20'h0000F, n: 8'd1, d: {20'h0, 20'h0, 20'h0, 20'h0000F}, exp_acc: 20'd225};
        tbl[4] = '{w: 20'h12345, n: 8'd0, d: {20'h0, 20'h0, 20'h0, 20'h0}, exp_acc: 20'd0};
        tbl[5] = '{w: 20'h00000, n: 8'd2, d: {20'h0, 20'h0, 20'hFFFFF, 20'hABCDE}, exp_acc: 20'd0};

        rst = 1'b1; w_load = 1'b0; w_data = '0; start = 1'b0; n_words = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset acc_out", 32'(acc_out), 32'd0);
        check("reset rd_en", 32'(rf_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word: read request then result two cycles later.
        @(negedge clk);
        w_load = 1'b1; w_data = 20'h11111;
        @(posedge clk);
        #1;
        w_load = 1'b0;
        push(20'h12345);
        start_job(20'h11111, 1'b0, 1);
        @(negedge clk);
        #1;
        check("t1 rd_en", 32'(rf_rd_en), 32'd1);
        check("t1 busy", 32'(busy), 32'd1);
        wait_result("t1", 15, 2, 0, 1'b0, 1);

        // Table vectors, weights loaded together with start.
        for (int i = 0; i < 6; i++) begin
            n = int'(tbl[i].n);
            for (int k = 0; k < n; k++) push(tbl[i].d[k]);
            start_job(tbl[i].w, 1'b1, n);
            wait_result($sformatf("vec%0d", i), int'(tbl[i].exp_acc), (n == 0) ? 1 : n + 2, i % 2, 1'b0, n);
        end

        // Longest job, back-to-back reads.
        for (int k = 0; k < 255; k++) push(20'hFFFFF);
        start_job(20'hFFFFF, 1'b1, 255);
        wait_result("full", 286875, 257, 0, 1'b0, 255);

        // Stall on empty file, with start/w_load attempts that must be ignored.
        sw[0] = 20'hFEDCB; sw[1] = 20'h13579; sw[2] = 20'h2468A; sw[3] = 20'h0F0F0;
        push(sw[0]); push(sw[1]);
        start_job(20'h12345, 1'b1, 4);
        @(negedge clk); #1; check("stall rd1", 32'(rf_rd_en), 32'd1);
        @(negedge clk); #1; check("stall rd2", 32'(rf_rd_en), 32'd1);
        @(negedge clk); #1; check("stall gap1", 32'(rf_rd_en), 32'd0);
        start = 1'b1; w_load = 1'b1; w_data = 20'h00000; n_words = 8'd7;
        @(posedge clk); #1; start = 1'b0; w_load = 1'b0;
        @(negedge clk); #1; check("stall gap2", 32'(rf_rd_en), 32'd0);
        @(negedge clk); #1; check("stall gap3", 32'(rf_rd_en), 32'd0);
        check("stall partial", 32'(acc_out), dot(20'h12345, sw[0]) + dot(20'h12345, sw[1]));
        check("stall busy", 32'(busy), 32'd1);
        check("stall no_valid", 32'(out_valid), 32'd0);
        push(sw[2]); push(sw[3]);
        exp_acc = 0;
        for (int k = 0; k < 4; k++) exp_acc += dot(20'h12345, sw[k]);
        wait_result("stall", exp_acc, -1, 5, 1'b0, 4);

        // Reset in the middle of a job.
        for (int k = 0; k < 5; k++) push(20'hFFFFF);
        start_job(20'h12345, 1'b1, 5);
        @(negedge clk); #1; check("rst rd1", 32'(rf_rd_en), 32'd1);
        @(negedge clk); #1; check("rst rd2", 32'(rf_rd_en), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst gates rd_en", 32'(rf_rd_en), 32'd0);
        @(negedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst acc_out", 32'(acc_out), 32'd0);
        rst = 1'b0;
        wr_cnt = rd_ptr;
        push(20'hFFFFF); push(20'h12345);
        start_job(20'h0, 1'b0, 2);
        wait_result("post_rst weights", 0, 4, 0, 1'b0, 2);

        // Random jobs with random file-empty gaps and backpressure.
        for (int j = 0; j < 25; j++) begin
            w = DW'($urandom);
            n = $urandom_range(1, 12);
            exp_acc = 0;
            for (int k = 0; k < n; k++) begin
                d = DW'($urandom);
                push(d);
                exp_acc = (exp_acc + dot(w, d)) % (1 << ACC_W);
            end
            start_job(w, 1'b1, n);
            wait_result($sformatf("rnd%0d", j), exp_acc, -1, $urandom_range(0, 3), 1'b1, n);
        end

        check("file underflow", underflows, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end

endmodule
